// File: rtl/shift_seq.sv
// shift_seq: serial SRL/SLL/SRA/ROR unit, one bit position per clock, start/busy/done handshake.
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int SAW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SAW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] b
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] work, step;
    logic [SAW-1:0] cnt;
    logic [1:0] md;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb
        state_nx = state == IDLE ? (start ? SHIFT : IDLE) : (cnt == '0 ? IDLE : SHIFT);
    always_comb
        busy = state == SHIFT;
    // every right-shifting mode differs only in the bit entering at the top
    always_comb
        step = md == 2'b01 ? {work[WIDTH-2:0], 1'b0}
             : {md == 2'b00 ? 1'b0 : md == 2'b10 ? work[WIDTH-1] : work[0], work[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
            md   <= '0;
            b    <= '0;
            done <= 1'b0;
        end else begin
            done <= busy && cnt == '0;
            if (!busy && start) begin
                work <= a;
                cnt  <= shamt;
                md   <= mode;
            end else if (busy && cnt != '0) begin
                work <= step;
                cnt  <= cnt - 1'b1;
            end else if (busy) begin
                b <= work;
            end
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized scoreboard bench for shift_seq against an arithmetic reference model.
module tb_shift_seq;
    logic clk = 0, rst = 1, start = 0, busy, done;
    logic [31:0] a = 0, b;
    logic [4:0] shamt = 0;
    logic [1:0] mode = 0;
    int errors = 0, checks = 0, cyc = 0;
    logic [31:0] held = 0;
    typedef struct { logic [31:0] val; int at; } exp_t;
    exp_t q[$];

    shift_seq #(.WIDTH(32), .SAW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt),
        .mode(mode), .busy(busy), .done(done), .b(b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(logic [1:0] m, logic [31:0] x, int s);
        logic [63:0] d;
        logic [31:0] r;
        d = {x, x} >> s;
        case (m)
            2'b00: r = x >> s;
            2'b01: r = x << s;
            2'b10: r = $signed(x) >>> s;
            default: r = d[31:0];
        endcase
        return r;
    endfunction

    // monitor: samples just after each rising edge, pops on done
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            q.delete();
            held = 0;
            checks++;
            if (busy !== 0 || done !== 0 || b !== 0) begin
                errors++;
                $display("FAIL reset: busy=%b done=%b b=%h, want 0 0 0", busy, done, b);
            end
        end else begin
            if (done === 1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: cycle %0d b=%h with nothing outstanding", cyc, b);
                end else begin
                    e = q.pop_front();
                    if (b !== e.val || cyc != e.at) begin
                        errors++;
                        $display("FAIL result: b=%h at cycle %0d, want %h at cycle %0d", b, cyc, e.val, e.at);
                    end
                    held = e.val;
                end
            end else begin
                checks++;
                if (b !== held) begin
                    errors++;
                    $display("FAIL hold: b=%h, want %h", b, held);
                end
            end
            checks++;
            if (busy !== (q.size() != 0)) begin
                errors++;
                $display("FAIL busy: busy=%b, want %b", busy, q.size() != 0);
            end
        end
    end

    // called at a falling edge; holds start for one cycle
    task automatic issue(logic [1:0] m, logic [31:0] x, logic [4:0] s);
        start = 1; mode = m; a = x; shamt = s;
        if (!busy && !rst) q.push_back('{ref_op(m, x, s), cyc + 1 + int'(s) + 1});
        @(negedge clk);
        start = 0; a = $urandom; mode = 2'($urandom); shamt = 5'($urandom);
    endtask

    // returns at the falling edge inside the done cycle
    task automatic wait_done(bit noise);
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                start = 0;
                return;
            end
            start = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (noise) begin a = $urandom; mode = 2'($urandom); shamt = 5'($urandom); end
            @(negedge clk);
        end
        start = 0;
        checks++;
        errors++;
        $display("FAIL timeout: no done within 100 cycles");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        issue(2'b10, 32'h80000000, 4);  wait_done(0);
        @(negedge clk);
        issue(2'b01, 32'h00000001, 31); wait_done(0);
        @(negedge clk);
        issue(2'b00, 32'h80000000, 31); wait_done(0);
        @(negedge clk);
        issue(2'b11, 32'h12345678, 8);  wait_done(0);
        @(negedge clk);
        issue(2'b11, 32'hDEADBEEF, 0);  wait_done(0);
        @(negedge clk);
        issue(2'b00, 32'hFFFF0000, 16);
        @(negedge clk);
        issue(2'b01, 32'h00000001, 3);
        wait_done(1);
        issue(2'b01, 32'h00000003, 2);  wait_done(0);
        @(negedge clk);
        issue(2'b10, 32'h9000_0001, 20);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        issue(2'b10, 32'h9000_0001, 20); wait_done(0);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(2'($urandom), $urandom, 5'($urandom_range(0, 31)));
            wait_done($urandom_range(0, 1) == 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
